// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared constants, field offsets and FSM state types for the
// PS/2 mouse receiver (ps2_rx_byte, ps2_mouse_rx).
// Optional feature macro: PS2_MOUSE_RX_PARITY_CHECK_EN (odd parity enforcement).
package ps2_mouse_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned PKT_BYTES  = 3;

  // Field offsets inside the 25-bit ps2_mouse bus
  localparam int unsigned STAT_LO = 0;
  localparam int unsigned X_LO    = 8;
  localparam int unsigned Y_LO    = 16;
  localparam int unsigned STB_BIT = 24;

  // Status byte bit indices
  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_M = 2;
  localparam int unsigned SYNC  = 3;
  localparam int unsigned XSIGN = 4;
  localparam int unsigned YSIGN = 5;

  typedef enum logic [1:0] {
    BYTE_IDLE,
    BYTE_DATA,
    BYTE_PARITY,
    BYTE_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    PKT_B0,
    PKT_B1,
    PKT_B2
  } pkt_state_t;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: PS/2 device-to-host byte receiver.
// Synchronises and filters raw PS/2 clock/data, samples data on each filtered
// clock falling edge, deserialises 11-bit frames and runs the inactivity timer.
// Optional feature macro: PS2_MOUSE_RX_PARITY_CHECK_EN (odd parity enforced in STOP).
// Ports:
//   clk, reset_n        system clock, async active-low reset
//   ps2_clk_i/data_i    raw asynchronous PS/2 pins
//   byte_valid          1-cycle pulse, byte_data holds the received byte
//   byte_data           last assembled byte
//   byte_err            1-cycle pulse on bad stop bit (or parity when enabled)
//   byte_busy           frame partially received
//   timeout             1-cycle strobe when the inactivity timer reaches its limit
module ps2_rx_byte
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err,
  output logic       byte_busy,
  output logic       timeout
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

  // Index 0 = clock, index 1 = data
  logic [1:0]     sync1, sync2, filt;
  logic [FCW-1:0] fcnt [2];
  logic           clk_prev;
  logic           clk_edge, clk_fall, bit_in;
  logic [TCW-1:0] to_cnt;

  byte_state_t state, state_d;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  shift, shift_d;
  logic        valid_d, err_d, par_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '1;
      sync2    <= '1;
      filt     <= '1;
      fcnt[0]  <= '0;
      fcnt[1]  <= '0;
      clk_prev <= 1'b1;
    end else begin
      sync1    <= {ps2_data_i, ps2_clk_i};
      sync2    <= sync1;
      clk_prev <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign clk_edge = clk_prev ^ filt[0];
  assign clk_fall = clk_prev & ~filt[0];
  assign bit_in   = filt[1];

  // An edge in the same cycle wins over the timer reaching its limit.
  assign timeout = ~clk_edge && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (clk_edge) begin
      to_cnt <= '0;
    end else if (to_cnt != TCW'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef PS2_MOUSE_RX_PARITY_CHECK_EN
  logic par_q, par_d;

  assign par_ok = odd_parity_ok(shift, par_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  always_comb begin
    par_d = par_q;
    if (clk_fall && state == BYTE_PARITY) begin
      par_d = bit_in;
    end
  end
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shift_d   = shift;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (clk_fall) begin
      case (state)
        BYTE_IDLE: begin
          if (!bit_in) begin
            state_d   = BYTE_DATA;
            bit_cnt_d = '0;
          end
        end
        BYTE_DATA: begin
          shift_d   = {bit_in, shift[7:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = BYTE_PARITY;
          end
        end
        BYTE_PARITY: begin
          state_d = BYTE_STOP;
        end
        BYTE_STOP: begin
          state_d = BYTE_IDLE;
          if (bit_in && par_ok) begin
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = BYTE_IDLE;
      endcase
    end else if (timeout) begin
      state_d = BYTE_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BYTE_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= bit_cnt_d;
      shift      <= shift_d;
      byte_valid <= valid_d;
      byte_err   <= err_d;
    end
  end

  assign byte_data = shift;
  assign byte_busy = (state != BYTE_IDLE);

endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 mouse receiver producing the 25-bit ps2_mouse packet bus.
// Assembles three bytes into {toggle, Y, X, status}; toggle flips per packet.
// Optional feature macro: PS2_MOUSE_RX_PARITY_CHECK_EN (odd parity enforcement).
// Ports:
//   clk, reset_n           system clock (clk_sys), async active-low reset
//   ps2_clk_i, ps2_data_i  raw asynchronous PS/2 pins
//   ps2_mouse[24:0]        [7:0] status, [15:8] X, [23:16] Y, [24] packet toggle
//   frame_err              1-cycle pulse on any dropped byte or packet
//   busy                   frame or packet partially received
module ps2_mouse_rx
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic [24:0] ps2_mouse,
  output logic        frame_err,
  output logic        busy
);

  logic       byte_valid, byte_err, byte_busy, timeout;
  logic [7:0] byte_data;

  pkt_state_t pkt, pkt_d;
  logic [7:0] b0, b1;
  logic       err_d, ld_b0, ld_b1, publish;

  ps2_rx_byte #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_err  (byte_err),
    .byte_busy (byte_busy),
    .timeout   (timeout)
  );

  // busy is sampled before the abort takes effect, so an idle timeout is silent.
  assign busy = byte_busy | (pkt != PKT_B0);

  always_comb begin
    pkt_d   = pkt;
    err_d   = 1'b0;
    ld_b0   = 1'b0;
    ld_b1   = 1'b0;
    publish = 1'b0;
    if (byte_err) begin
      pkt_d = PKT_B0;
      err_d = 1'b1;
    end else if (byte_valid) begin
      case (pkt)
        PKT_B0: begin
          if (byte_data[SYNC]) begin
            ld_b0 = 1'b1;
            pkt_d = PKT_B1;
          end else begin
            err_d = 1'b1;
          end
        end
        PKT_B1: begin
          ld_b1 = 1'b1;
          pkt_d = PKT_B2;
        end
        PKT_B2: begin
          publish = 1'b1;
          pkt_d   = PKT_B0;
        end
        default: pkt_d = PKT_B0;
      endcase
    end else if (timeout && busy) begin
      pkt_d = PKT_B0;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt       <= PKT_B0;
      b0        <= '0;
      b1        <= '0;
      ps2_mouse <= '0;
      frame_err <= 1'b0;
    end else begin
      pkt       <= pkt_d;
      frame_err <= err_d;
      if (ld_b0) begin
        b0 <= byte_data;
      end
      if (ld_b1) begin
        b1 <= byte_data;
      end
      if (publish) begin
        ps2_mouse[STAT_LO +: 8] <= b0;
        ps2_mouse[X_LO +: 8]    <= b1;
        ps2_mouse[Y_LO +: 8]    <= byte_data;
        ps2_mouse[STB_BIT]      <= ~ps2_mouse[STB_BIT];
      end
    end
  end

endmodule
